// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS BCD stopwatch.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned DISP_W       = 4 * DIGIT_W;
  localparam int unsigned ONES_MAX     = 9;
  localparam int unsigned SEC_TENS_MAX = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } mmss_t;

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Control inputs and display outputs of the stopwatch, grouped as one bundle.
interface bcd_stopwatch_if;
  import stopwatch_pkg::*;

  logic              tick_in;
  logic              start_stop_in;
  logic              clear_in;
  logic              lap_in;
  logic [DISP_W-1:0] digits_out;
  logic              running;
  logic              lap_active;
  logic              wrap_pulse;

  modport master (
    output tick_in, start_stop_in, clear_in, lap_in,
    input  digits_out, running, lap_active, wrap_pulse
  );

  modport slave (
    input  tick_in, start_stop_in, clear_in, lap_in,
    output digits_out, running, lap_active, wrap_pulse
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD counter digit that wraps at MAX; chained through carry_out -> inc.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX = 9
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out
);

  logic [DIGIT_W-1:0] value_q;
  logic [DIGIT_W-1:0] value_d;
  logic               at_max_c;

  assign at_max_c = (value_q == DIGIT_W'(MAX));

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = at_max_c ? '0 : value_q + DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) value_q <= '0;
    else      value_q <= value_d;
  end

  assign value     = value_q;
  assign carry_out = inc & at_max_c;

endmodule

// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch advanced by rising edges of the divided tick, with run/pause,
// clear and lap-freeze control, all on the board clock.
module bcd_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned MIN_TENS_MAX = 5,
  parameter int unsigned LAP_EN       = 1
) (
  input  logic           clk_in,
  input  logic           rst,
  bcd_stopwatch_if.slave sw
);

  state_t state_q, state_d;
  mmss_t  lap_q, lap_d;
  mmss_t  live_c;
  logic   tick_q;
  logic   lap_active_q, lap_active_d;
  logic   wrap_q, wrap_d;
  logic   running_q, running_d;
  logic   tick_rise_c;
  logic   advance_c;
  logic   clr_c;
  logic   c_so, c_st, c_mo, c_mt;

  logic [DIGIT_W-1:0] so_val, st_val, mo_val, mt_val;

  assign tick_rise_c = sw.tick_in & ~tick_q;
  assign live_c      = {mt_val, mo_val, st_val, so_val};

  // Next state, lap capture and advance enable; clear outranks everything.
  always_comb begin
    state_d      = state_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    advance_c    = 1'b0;
    clr_c        = 1'b0;
    if (sw.clear_in) begin
      state_d      = ST_IDLE;
      clr_c        = 1'b1;
      lap_active_d = 1'b0;
    end else begin
      if (sw.start_stop_in) begin
        case (state_q)
          ST_IDLE:  state_d = ST_RUN;
          ST_RUN:   state_d = ST_PAUSE;
          ST_PAUSE: state_d = ST_RUN;
          default:  state_d = ST_IDLE;
        endcase
      end else if (state_q == ST_RUN && tick_rise_c) begin
        advance_c = 1'b1;
      end
      if (LAP_EN != 0 && sw.lap_in) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else if (state_q != ST_IDLE) begin
          lap_d        = live_c;
          lap_active_d = 1'b1;
        end
      end
    end
  end

  assign wrap_d    = c_mt;
  assign running_d = (state_d == ST_RUN);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      tick_q       <= 1'b0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      tick_q       <= sw.tick_in;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      wrap_q       <= wrap_d;
      running_q    <= running_d;
    end
  end

  bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clk_in(clk_in), .rst(rst), .clr(clr_c), .inc(advance_c),
    .value(so_val), .carry_out(c_so)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk_in(clk_in), .rst(rst), .clr(clr_c), .inc(c_so),
    .value(st_val), .carry_out(c_st)
  );

  bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clk_in(clk_in), .rst(rst), .clr(clr_c), .inc(c_st),
    .value(mo_val), .carry_out(c_mo)
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk_in(clk_in), .rst(rst), .clr(clr_c), .inc(c_mo),
    .value(mt_val), .carry_out(c_mt)
  );

  // Display selects between two registers only, so no input reaches it combinationally.
  assign sw.digits_out = lap_active_q ? lap_q : live_c;
  assign sw.running    = running_q;
  assign sw.lap_active = lap_active_q;
  assign sw.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Randomized and directed bench for bcd_stopwatch against a seconds-count model.
module tb_bcd_stopwatch;

  localparam int unsigned MTM    = 5;
  localparam int          MAXSEC = (MTM * 10 + 10) * 60;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bcd_stopwatch_if sw ();

  bcd_stopwatch #(.MIN_TENS_MAX(MTM), .LAP_EN(1)) dut (
    .clk_in(clk),
    .rst   (rst),
    .sw    (sw)
  );

  int total = 0;
  int bad   = 0;

  // Model: elapsed seconds as a plain integer, run/started flags, frozen lap value.
  int          m_cnt, m_lapv;
  bit          m_run, m_started, m_lap, m_wrap, m_tprev, m_rise;
  logic [15:0] m_exp;
  logic        rt;

  function automatic logic [15:0] to_bcd(input int s);
    int m, sec;
    m   = s / 60;
    sec = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_lapv = 0; m_run = 0; m_started = 0;
      m_lap = 0; m_wrap = 0; m_tprev = 0;
    end else begin
      m_rise  = sw.tick_in && !m_tprev;
      m_tprev = sw.tick_in;
      m_wrap  = 0;
      if (sw.clear_in) begin
        m_run = 0; m_started = 0; m_cnt = 0; m_lap = 0;
      end else begin
        if (sw.lap_in) begin
          if (m_lap) m_lap = 0;
          else if (m_started) begin m_lapv = m_cnt; m_lap = 1; end
        end
        if (sw.start_stop_in) begin
          m_run = !m_run; m_started = 1;
        end else if (m_run && m_rise) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == MAXSEC) begin m_cnt = 0; m_wrap = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      m_exp = m_lap ? to_bcd(m_lapv) : to_bcd(m_cnt);
      total++;
      if (sw.digits_out !== m_exp || sw.running !== m_run ||
          sw.lap_active !== m_lap || sw.wrap_pulse !== m_wrap) begin
        bad++;
        $display("FAIL model_cmp t=%0t got d=%h r=%b l=%b w=%b want d=%h r=%b l=%b w=%b",
                 $time, sw.digits_out, sw.running, sw.lap_active, sw.wrap_pulse,
                 m_exp, m_run, m_lap, m_wrap);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic step(input logic t, input logic ss, input logic cl, input logic lp);
    @(negedge clk);
    sw.tick_in       = t;
    sw.start_stop_in = ss;
    sw.clear_in      = cl;
    sw.lap_in        = lp;
  endtask

  task automatic ticks(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      repeat (hi) step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (lo) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    sw.tick_in = 1'b0; sw.start_stop_in = 1'b0; sw.clear_in = 1'b0; sw.lap_in = 1'b0;
    rt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digits",  32'(sw.digits_out), 32'h0000);
    chk("rst_running", 32'(sw.running),    32'd0);
    chk("rst_lap",     32'(sw.lap_active), 32'd0);
    chk("rst_wrap",    32'(sw.wrap_pulse), 32'd0);
    rst = 1'b1;

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10, 4, 4);
    chk("ten_ticks", 32'(sw.digits_out), 32'h0010);
    chk("ten_running", 32'(sw.running), 32'd1);

    repeat (50) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("hold_high", 32'(sw.digits_out), 32'h0011);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3599, 1, 1);
    chk("preload", 32'(sw.digits_out), 32'h5959);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("wrap_digits", 32'(sw.digits_out), 32'h0000);
    chk("wrap_pulse",  32'(sw.wrap_pulse), 32'd1);
    @(posedge clk); #1;
    chk("wrap_once",   32'(sw.wrap_pulse), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(7, 4, 4);
    chk("lap_at7", 32'(sw.digits_out), 32'h0007);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ticks(5, 4, 4);
    chk("lap_frozen", 32'(sw.digits_out), 32'h0007);
    chk("lap_active", 32'(sw.lap_active), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lap_release", 32'(sw.digits_out), 32'h0012);
    chk("lap_off", 32'(sw.lap_active), 32'd0);

    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(42, 2, 2);
    chk("at42", 32'(sw.digits_out), 32'h0042);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_digits",  32'(sw.digits_out), 32'h0000);
    chk("clr_running", 32'(sw.running),    32'd0);
    chk("clr_lap",     32'(sw.lap_active), 32'd0);

    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(83, 2, 2);
    chk("at123", 32'(sw.digits_out), 32'h0123);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_digits",  32'(sw.digits_out), 32'h0000);
    chk("async_running", 32'(sw.running),    32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    ticks(5, 2, 2);
    chk("no_adv_idle", 32'(sw.digits_out), 32'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1, 2, 2);
    chk("adv_after_start", 32'(sw.digits_out), 32'h0001);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) rt = ~rt;
      step(rt,
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 299) == 0),
           1'($urandom_range(0, 39) == 0));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
